led_adc_sequencer: RTL
======================

# led_adc_sequencer

Time-multiplexing controller for the finger-clip front end. It alternates the IR and red LEDs at 100 Hz and triggers one ADC conversion per LED phase after a settle delay. Each result is steered into a per-channel sample register with a one-cycle valid strobe, which the IR and red FIR filter instances use as their sample-advance enable. It sits between the ADC interface and the two 8-bit-input FIR filters.

## Interface

Parameters:
- HALF_PERIOD, 50000: cycles per LED phase (5 ms at 10 MHz → 100 Hz full IR+red period).
- SETTLE_CYC, 5000: cycles after LED switch-on before ADC_Start.
- ADC_TIMEOUT, 1000: max cycles to wait for ADC_Done.
- Constraint: SETTLE_CYC + ADC_TIMEOUT + 4 ≤ HALF_PERIOD, SETTLE_CYC ≥ 1; checked at elaboration.

Ports:
- CLK_Sys in 1: system clock; single clock domain.
- rst_n in 1: synchronous, active-low reset.
- enable in 1: run sequencing; low forces IDLE.
- ADC_Done in 1: one-cycle pulse, ADC_Data valid in same cycle.
- ADC_Data in 8: conversion result.
- ADC_Start out 1: one-cycle conversion request.
- LED_IR_On out 1: IR LED drive.
- LED_Red_On out 1: red LED drive.
- IR_ADC_Value out 8: last IR sample, held.
- Red_ADC_Value out 8: last red sample, held.
- IR_Sample_Valid out 1: one-cycle strobe, IR_ADC_Value updated.
- Red_Sample_Valid out 1: one-cycle strobe, Red_ADC_Value updated.
- ADC_Timeout_Err out 1: sticky; cleared only by reset.

## Operation

- FSM states: IDLE, SETTLE, CONVERT, WAIT_DONE, HOLD. Phase bit `ph` selects the channel: 0 = IR, 1 = red.
- IDLE: LEDs off, counter 0, ph = 0. Goes to SETTLE when enable = 1.
- Phase counter cnt runs 0..HALF_PERIOD-1 in every non-IDLE state. At the HALF_PERIOD-1 wrap: ph toggles, cnt = 0, state = SETTLE, regardless of current state.
- LED drive:
  - LED_IR_On = (state≠IDLE) & ~ph.
  - LED_Red_On = (state≠IDLE) & ph.
  - Never both high. Switch-over happens in a single clock edge.
- SETTLE: when cnt = SETTLE_CYC-1, go to CONVERT.
- CONVERT: ADC_Start = 1 for exactly this one cycle, then WAIT_DONE. A timeout counter is cleared.
- WAIT_DONE:
  - On ADC_Done: ADC_Data is latched into the ph channel's register, that channel's Valid is strobed next cycle, then HOLD.
  - If the timeout counter reaches ADC_TIMEOUT with no Done: ADC_Timeout_Err is set, then HOLD. No valid strobe, and the previous sample is kept.
  - Done and timeout in the same cycle: Done wins, no error.
- HOLD: idle until the wrap.
- ADC_Done outside WAIT_DONE is ignored; no register or strobe changes.
- enable falls mid-phase: IDLE on the next edge. LEDs off, any in-flight conversion discarded, sample registers and the error flag kept. Re-enable always starts with IR.
- At most one valid strobe per phase, so each filter advances at exactly 100 Hz.

## Timing

- Reset (rst_n = 0 at the edge) values:
  - all outputs 0;
  - state IDLE, ph = 0, counters 0.
- Reset takes priority over enable.
- First ADC_Start occurs SETTLE_CYC cycles after the first enabled cycle.
- Latency from ADC_Done edge to X_ADC_Value update: 1 cycle. The Valid strobe is asserted in that same cycle as the registered value (value and strobe coincident).
- ADC_Start is registered, with no combinational path from inputs to outputs.

## Structure

- A shared package holds:
  - the state enum (IDLE, SETTLE, CONVERT, WAIT_DONE, HOLD);
  - the channel encoding constants (CH_IR = 0, CH_RED = 1);
  - the 8-bit sample width constant shared with the FIR filters.
- Sub-module `phase_timer`: a parameterised free-running counter with a wrap pulse and a compare-match output for SETTLE_CYC. Everything else stays in a single module.

## Test plan

Small parameters: HALF_PERIOD = 40, SETTLE_CYC = 5, ADC_TIMEOUT = 8.

- **Reset/enable:** enable = 1 after reset.
  - LED_IR_On high from the first enabled cycle.
  - ADC_Start at cycle 5.
  - LED_Red_On high at cycle 40; IR drops on the same edge.
- **Normal capture:** ADC responds with Done 3 cycles after Start, data 0xA5 during IR and 0x3C during red.
  - IR_ADC_Value = 0xA5 with IR_Sample_Valid for 1 cycle.
  - Then Red_ADC_Value = 0x3C with Red_Sample_Valid.
  - Exactly one strobe per 40 cycles per channel.
- **Timeout:** ADC never responds in a red phase.
  - ADC_Timeout_Err sets 8 cycles after Start and stays set.
  - No Red_Sample_Valid; Red_ADC_Value is unchanged.
  - The next IR phase still captures.
- **Races:**
  - Done on the same cycle as the timeout → sample taken, no error.
  - Spurious Done in SETTLE/HOLD → ignored.
- **Mid-conversion disable:** enable drops in WAIT_DONE, then Done arrives.
  - No strobe; LEDs off next edge.
  - Re-enable restarts with IR and Start 5 cycles later.
- **Reset mid-operation:** rst_n low during HOLD with Red_ADC_Value = 0x3C → all outputs 0 the next edge, including the sample registers and the error flag.

Source files
------------

// File: rtl/led_adc_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : led_adc_sequencer_pkg                                      |
// | Purpose : Shared types and constants for the LED/ADC sequencer and   |
// |           the downstream FIR filters.                                |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package led_adc_sequencer_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    CONVERT   = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } state_e;

  // Channel encoding of the phase bit
  localparam logic CH_IR  = 1'b0;
  localparam logic CH_RED = 1'b1;

  // Sample width shared with the FIR filter inputs
  localparam int unsigned SAMPLE_W = 8;

endpackage : led_adc_sequencer_pkg
`default_nettype wire

// File: rtl/led_adc_sequencer_phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : phase_timer                                                |
// | Purpose : Phase counter 0..HALF_PERIOD-1 with a wrap flag on the     |
// |           last count and a match flag on count SETTLE_CYC-1. Held    |
// |           at zero while not running.                                 |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module phase_timer #(
  parameter int unsigned HALF_PERIOD = 50000,
  parameter int unsigned SETTLE_CYC  = 5000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic wrap_o,
  output logic match_o
);

  localparam int unsigned      c_CNT_W = $clog2(HALF_PERIOD);
  localparam logic [c_CNT_W-1:0] c_WRAP  = c_CNT_W'(HALF_PERIOD - 1);
  localparam logic [c_CNT_W-1:0] c_MATCH = c_CNT_W'(SETTLE_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [c_CNT_W-1:0] cnt_q;
  logic [c_CNT_W-1:0] cnt_d;

  assign wrap_o  = (cnt_q == c_WRAP);
  assign match_o = (cnt_q == c_MATCH);

  // Next count: advance while running, restart at the wrap, clear when stopped
  always_comb begin
    cnt_d = '0;
    if (run_i && !wrap_o) begin
      cnt_d = cnt_q + c_ONE;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : phase_timer
`default_nettype wire

// File: rtl/led_adc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : led_adc_sequencer                                          |
// | Purpose : Alternates IR and red LED phases, starts one ADC           |
// |           conversion per phase after a settle delay and steers the   |
// |           result to a per-channel register with a one-cycle strobe.  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module led_adc_sequencer
  import led_adc_sequencer_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 50000,
  parameter int unsigned SETTLE_CYC  = 5000,
  parameter int unsigned ADC_TIMEOUT = 1000
) (
  input  logic                CLK_Sys,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                ADC_Done,
  input  logic [SAMPLE_W-1:0] ADC_Data,
  output logic                ADC_Start,
  output logic                LED_IR_On,
  output logic                LED_Red_On,
  output logic [SAMPLE_W-1:0] IR_ADC_Value,
  output logic [SAMPLE_W-1:0] Red_ADC_Value,
  output logic                IR_Sample_Valid,
  output logic                Red_Sample_Valid,
  output logic                ADC_Timeout_Err
);

  generate
    if ((SETTLE_CYC < 1) || (SETTLE_CYC + ADC_TIMEOUT + 4 > HALF_PERIOD)) begin : g_param_check
      $error("led_adc_sequencer: need SETTLE_CYC >= 1 and SETTLE_CYC + ADC_TIMEOUT + 4 <= HALF_PERIOD");
    end
  endgenerate

  // The timeout counter holds cycles elapsed since ADC_Start; it is zero
  // during CONVERT so the last WAIT_DONE cycle sees ADC_TIMEOUT-1.
  localparam int unsigned        c_TMO_W    = $clog2(ADC_TIMEOUT + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(ADC_TIMEOUT - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);

  state_e                state_q, state_d;
  logic                  ph_q, ph_d;
  logic [c_TMO_W-1:0]    tcnt_q, tcnt_d;
  logic                  start_q, start_d;
  logic [SAMPLE_W-1:0]   ir_val_q, ir_val_d;
  logic [SAMPLE_W-1:0]   red_val_q, red_val_d;
  logic                  ir_vld_q, ir_vld_d;
  logic                  red_vld_q, red_vld_d;
  logic                  err_q, err_d;

  logic                  w_run;
  logic                  w_wrap;
  logic                  w_settle_done;

  assign w_run = enable && (state_q != IDLE);

  phase_timer #(
    .HALF_PERIOD (HALF_PERIOD),
    .SETTLE_CYC  (SETTLE_CYC)
  ) u_phase_timer (
    .clk_i   (CLK_Sys),
    .rst_ni  (rst_n),
    .run_i   (w_run),
    .wrap_o  (w_wrap),
    .match_o (w_settle_done)
  );

  // Next-state logic: disable beats the phase wrap, which beats any state step
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    tcnt_d    = tcnt_q;
    ir_val_d  = ir_val_q;
    red_val_d = red_val_q;
    ir_vld_d  = 1'b0;
    red_vld_d = 1'b0;
    err_d     = err_q;

    if (!enable) begin
      state_d = IDLE;
      ph_d    = CH_IR;
      tcnt_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = SETTLE;
      ph_d    = CH_IR;
    end else if (w_wrap) begin
      state_d = SETTLE;
      ph_d    = ~ph_q;
    end else begin
      case (state_q)
        SETTLE: begin
          if (w_settle_done) begin
            state_d = CONVERT;
            tcnt_d  = '0;
          end
        end
        CONVERT: begin
          state_d = WAIT_DONE;
          tcnt_d  = tcnt_q + c_TMO_ONE;
        end
        WAIT_DONE: begin
          tcnt_d = tcnt_q + c_TMO_ONE;
          if (ADC_Done) begin
            // Done wins over a coincident timeout
            state_d = HOLD;
            if (ph_q == CH_IR) begin
              ir_val_d = ADC_Data;
              ir_vld_d = 1'b1;
            end else begin
              red_val_d = ADC_Data;
              red_vld_d = 1'b1;
            end
          end else if (tcnt_q >= c_TMO_LAST) begin
            state_d = HOLD;
            err_d   = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    start_d = (state_d == CONVERT);
  end

  // State and output registers
  always_ff @(posedge CLK_Sys) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ph_q      <= CH_IR;
      tcnt_q    <= '0;
      start_q   <= 1'b0;
      ir_val_q  <= '0;
      red_val_q <= '0;
      ir_vld_q  <= 1'b0;
      red_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      tcnt_q    <= tcnt_d;
      start_q   <= start_d;
      ir_val_q  <= ir_val_d;
      red_val_q <= red_val_d;
      ir_vld_q  <= ir_vld_d;
      red_vld_q <= red_vld_d;
      err_q     <= err_d;
    end
  end

  assign ADC_Start        = start_q;
  assign LED_IR_On        = (state_q != IDLE) && (ph_q == CH_IR);
  assign LED_Red_On       = (state_q != IDLE) && (ph_q == CH_RED);
  assign IR_ADC_Value     = ir_val_q;
  assign Red_ADC_Value    = red_val_q;
  assign IR_Sample_Valid  = ir_vld_q;
  assign Red_Sample_Valid = red_vld_q;
  assign ADC_Timeout_Err  = err_q;

endmodule : led_adc_sequencer
`default_nettype wire
